// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posts MEM-stage stores into a DEPTH-entry FIFO, drains
// them to a single-port valid/ready memory bus, and sequences loads onto the
// same bus. StallMem tells the hazard unit when the MEM stage cannot complete.
// Optional feature macro: STORE_BUF_FWD_EN (full-word store-to-load forwarding).
module dmem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  byteEnable,
  output logic        StallMem,
  output logic [31:0] RD_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] DRAIN = 2'b01;
  localparam logic [1:0] LOAD  = 2'b10;

  logic [29:0]   fifoAddrR [DEPTH];
  logic [31:0]   fifoDataR [DEPTH];
  logic [3:0]    fifoBeR   [DEPTH];
  logic [CW-1:0] wrPtrR;
  logic [CW-1:0] rdPtrR;
  logic [1:0]    stateR;
  logic [1:0]    stateNextS;

  logic [CW-1:0] countS;
  logic [CW-1:0] countNextS;
  logic [PW-1:0] headIdxS;
  logic [PW-1:0] wrIdxS;
  logic [PW-1:0] scanIdxS;
  logic [29:0]   loadWordS;
  logic          fullS;
  logic          storeReqS;
  logic          enqS;
  logic          deqS;
  logic          loadDoneS;
  logic          loadPendingS;
  logic          storeBlockedS;
  logic          hazardPostS;
  logic          fwdHitS;

  // Extra pointer bit makes the difference a true occupancy count (full vs empty)
  assign headIdxS      = rdPtrR[PW-1:0];
  assign wrIdxS        = wrPtrR[PW-1:0];
  assign countS        = wrPtrR - rdPtrR;
  assign fullS         = (countS == CW'(DEPTH));
  assign loadWordS     = ALUResultM[31:2];
  // A simultaneous store+load is treated as a load only
  assign storeReqS     = MemWriteM & ~MemReadM;
  assign deqS          = (stateR == DRAIN) & mem_ready;
  assign loadDoneS     = (stateR == LOAD) & mem_ready;
  assign loadPendingS  = MemReadM & ~loadDoneS & ~fwdHitS;
  assign storeBlockedS = storeReqS & fullS & ~deqS;
  assign StallMem      = loadPendingS | storeBlockedS;
  assign enqS          = storeReqS & ~StallMem;
  assign countNextS    = countS + CW'(enqS) - CW'(deqS);

  // Load hazard against entries still queued after this cycle's dequeue
  always_comb begin
    hazardPostS = 1'b0;
    scanIdxS    = {PW{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      scanIdxS    = headIdxS + PW'(k);
      hazardPostS = hazardPostS |
                    ((k < int'(countS)) && (fifoAddrR[scanIdxS] == loadWordS) &&
                     !(deqS && (k == 0)));
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [31:0]   fwdDataS;
  logic          fwdMatchS;
  logic          fwdFullS;
  logic [PW-1:0] fwdIdxS;

  // Youngest matching entry wins: later iterations are younger
  always_comb begin
    fwdDataS  = 32'h0000_0000;
    fwdMatchS = 1'b0;
    fwdFullS  = 1'b0;
    fwdIdxS   = {PW{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      fwdIdxS = headIdxS + PW'(k);
      if ((k < int'(countS)) && (fifoAddrR[fwdIdxS] == loadWordS)) begin
        fwdDataS  = fifoDataR[fwdIdxS];
        fwdMatchS = 1'b1;
        fwdFullS  = (fifoBeR[fwdIdxS] == 4'b1111);
      end else begin
      end
    end
  end

  assign fwdHitS = MemReadM & fwdMatchS & fwdFullS;
  assign RD_data = fwdHitS ? fwdDataS : mem_rdata;
`else
  assign fwdHitS = 1'b0;
  assign RD_data = mem_rdata;
`endif

  // Next-state: loads have priority from IDLE; drains never get preempted
  always_comb begin
    stateNextS = stateR;
    case (stateR)
      IDLE, DRAIN: begin
        if ((stateR == DRAIN) && !mem_ready) begin
          stateNextS = DRAIN;
        end else if (MemReadM && !hazardPostS && !fwdHitS) begin
          stateNextS = LOAD;
        end else if (countNextS != {CW{1'b0}}) begin
          stateNextS = DRAIN;
        end else begin
          stateNextS = IDLE;
        end
      end
      LOAD: begin
        if (!mem_ready) begin
          stateNextS = LOAD;
        end else if (countNextS != {CW{1'b0}}) begin
          stateNextS = DRAIN;
        end else begin
          stateNextS = IDLE;
        end
      end
      default: stateNextS = IDLE;
    endcase
  end

  // Bus outputs decoded from the current state
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    mem_be    = 4'b0000;
    case (stateR)
      DRAIN: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {fifoAddrR[headIdxS], 2'b00};
        mem_wdata = fifoDataR[headIdxS];
        mem_be    = fifoBeR[headIdxS];
      end
      LOAD: begin
        mem_req  = 1'b1;
        mem_addr = {loadWordS, 2'b00};
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // State and FIFO pointers; reset aborts any bus transaction and empties the FIFO
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      stateR <= IDLE;
      wrPtrR <= {CW{1'b0}};
      rdPtrR <= {CW{1'b0}};
    end else begin
      stateR <= stateNextS;
      wrPtrR <= wrPtrR + CW'(enqS);
      rdPtrR <= rdPtrR + CW'(deqS);
    end
  end

  // FIFO storage: stores are lane-aligned on entry
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifoAddrR[i] <= 30'h0000_0000;
        fifoDataR[i] <= 32'h0000_0000;
        fifoBeR[i]   <= 4'b0000;
      end
    end else if (enqS) begin
      fifoAddrR[wrIdxS] <= ALUResultM[31:2];
      fifoDataR[wrIdxS] <= WriteDataM << {ALUResultM[1:0], 3'b000};
      fifoBeR[wrIdxS]   <= byteEnable;
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed self-checking bench for dmem_store_buffer (DEPTH = 4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        MemWriteM;
  logic        MemReadM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [3:0]  byteEnable;
  logic        StallMem;
  logic [31:0] RD_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  dmem_store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .clr_n(clr_n), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .byteEnable(byteEnable),
    .StallMem(StallMem), .RD_data(RD_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    MemWriteM = 1'b0; MemReadM = 1'b0; ALUResultM = 32'h0; WriteDataM = 32'h0;
    byteEnable = 4'b0000; mem_ready = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    MemWriteM = 1'b1; MemReadM = 1'b0; ALUResultM = a; WriteDataM = d; byteEnable = be;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    idleInputs();
    #2;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", mem_req); end
    checks++; if (StallMem !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0h exp=0", StallMem); end
    MemReadM = 1'b1; mem_rdata = 32'h0000_1234;
    #1;
    checks++; if (StallMem !== 1'b1) begin failures++; $display("FAIL rst_stall_comb got=%0h exp=1", StallMem); end
    checks++; if (RD_data !== 32'h0000_1234) begin failures++; $display("FAIL rst_rd got=%h exp=00001234", RD_data); end
    idleInputs();
    repeat (2) @(posedge clk);
    #3 clr_n = 1'b1;
    cyc();
    mid();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_idle got=%0h exp=0", mem_req); end
    cyc();
  endtask

  task automatic test_sw();
    mem_ready = 1'b1;
    store(32'h100, 32'hDEADBEEF, 4'b1111);
    mid();
    checks++; if (StallMem !== 1'b0) begin failures++; $display("FAIL sw_stall got=%0h exp=0", StallMem); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL sw_req0 got=%0h exp=0", mem_req); end
    cyc();
    MemWriteM = 1'b0;
    mid();
    checks++; if ({mem_req, mem_we} !== 2'b11) begin failures++; $display("FAIL sw_reqwe got=%b exp=11", {mem_req, mem_we}); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL sw_addr got=%h exp=00000100", mem_addr); end
    checks++; if (mem_be !== 4'b1111) begin failures++; $display("FAIL sw_be got=%b exp=1111", mem_be); end
    checks++; if (mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", mem_wdata); end
    cyc();
    mid();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL sw_empty got=%0h exp=0", mem_req); end
    cyc();
    mem_ready = 1'b0;
  endtask

  task automatic test_sub_word();
    mem_ready = 1'b0;
    store(32'h203, 32'h0000_00AB, 4'b1000);
    cyc();
    store(32'h202, 32'h0000_1234, 4'b1100);
    mid();
    checks++; if (mem_wdata !== 32'hAB00_0000) begin failures++; $display("FAIL sb_wdata got=%h exp=ab000000", mem_wdata); end
    checks++; if (mem_be !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", mem_be); end
    checks++; if (mem_addr !== 32'h200) begin failures++; $display("FAIL sb_addr got=%h exp=00000200", mem_addr); end
    cyc();
    MemWriteM = 1'b0; mem_ready = 1'b1;
    mid();
    checks++; if (mem_wdata !== 32'hAB00_0000) begin failures++; $display("FAIL sb_hold got=%h exp=ab000000", mem_wdata); end
    cyc();
    mid();
    checks++; if (mem_wdata !== 32'h1234_0000) begin failures++; $display("FAIL sh_wdata got=%h exp=12340000", mem_wdata); end
    checks++; if (mem_be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", mem_be); end
    cyc();
    mem_ready = 1'b0;
    mid();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL sh_idle got=%0h exp=0", mem_req); end
    cyc();
  endtask

  task automatic test_full();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(32'h10 + 32'(4 * i), 32'(i + 1), 4'b1111);
      mid();
      checks++; if (StallMem !== 1'b0) begin failures++; $display("FAIL full_fill%0d got=%0h exp=0", i, StallMem); end
      cyc();
    end
    store(32'h20, 32'd5, 4'b1111);
    mid();
    checks++; if (StallMem !== 1'b1) begin failures++; $display("FAIL full_stall got=%0h exp=1", StallMem); end
    cyc();
    mem_ready = 1'b1;
    mid();
    checks++; if (StallMem !== 1'b0) begin failures++; $display("FAIL full_swap got=%0h exp=0", StallMem); end
    checks++; if (mem_addr !== 32'h10) begin failures++; $display("FAIL full_head got=%h exp=00000010", mem_addr); end
    cyc();
    store(32'h24, 32'd6, 4'b1111);
    mem_ready = 1'b0;
    mid();
    checks++; if (StallMem !== 1'b1) begin failures++; $display("FAIL full_still got=%0h exp=1", StallMem); end
    checks++; if (mem_addr !== 32'h14) begin failures++; $display("FAIL full_head2 got=%h exp=00000014", mem_addr); end
    cyc();
    MemWriteM = 1'b0; mem_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      mid();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h14 + 32'(4 * j)) begin failures++; $display("FAIL drain%0d_addr got=%h req=%0h exp=%h", j, mem_addr, mem_req, 32'h14 + 32'(4 * j)); end
      checks++; if (mem_wdata !== 32'(j + 2)) begin failures++; $display("FAIL drain%0d_data got=%h exp=%h", j, mem_wdata, 32'(j + 2)); end
      cyc();
    end
    mem_ready = 1'b0;
    mid();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL full_idle got=%0h exp=0", mem_req); end
    cyc();
  endtask

  task automatic test_load();
    int stallCycles;
    stallCycles = 0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    MemReadM = 1'b1; ALUResultM = 32'h300;
    mid();
    if (StallMem === 1'b1) stallCycles++;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL ld_c0_req got=%0h exp=0", mem_req); end
    cyc();
    for (int c = 1; c < 4; c++) begin
      mid();
      if (StallMem === 1'b1) stallCycles++;
      checks++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h300) begin failures++; $display("FAIL ld_c%0d_bus got=%b/%h exp=10/00000300", c, {mem_req, mem_we}, mem_addr); end
      cyc();
    end
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    mid();
    if (StallMem === 1'b1) stallCycles++;
    checks++; if (StallMem !== 1'b0) begin failures++; $display("FAIL ld_done_stall got=%0h exp=0", StallMem); end
    checks++; if (RD_data !== 32'hCAFEF00D) begin failures++; $display("FAIL ld_rdata got=%h exp=cafef00d", RD_data); end
    checks++; if (stallCycles !== 4) begin failures++; $display("FAIL ld_stall_cycles got=%0d exp=4", stallCycles); end
    cyc();
    idleInputs();
    mid();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL ld_idle got=%0h exp=0", mem_req); end
    cyc();
  endtask

  task automatic test_hazard();
    mem_ready = 1'b0;
    store(32'h400, 32'h11223344, 4'b1111);
    cyc();
    MemWriteM = 1'b0; MemReadM = 1'b1; ALUResultM = 32'h400;
`ifdef STORE_BUF_FWD_EN
    mid();
    checks++; if (StallMem !== 1'b0) begin failures++; $display("FAIL fwd_stall got=%0h exp=0", StallMem); end
    checks++; if (RD_data !== 32'h11223344) begin failures++; $display("FAIL fwd_data got=%h exp=11223344", RD_data); end
    cyc();
    MemReadM = 1'b0; mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
`else
    mid();
    checks++; if (StallMem !== 1'b1) begin failures++; $display("FAIL haz_stall got=%0h exp=1", StallMem); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h400) begin failures++; $display("FAIL haz_drain got=%0h/%h exp=1/00000400", mem_we, mem_addr); end
    cyc();
    mem_ready = 1'b1;
    mid();
    checks++; if (StallMem !== 1'b1) begin failures++; $display("FAIL haz_stall2 got=%0h exp=1", StallMem); end
    cyc();
    mem_ready = 1'b0;
    mid();
    checks++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h400) begin failures++; $display("FAIL haz_load got=%b/%h exp=10/00000400", {mem_req, mem_we}, mem_addr); end
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0055;
    mid();
    checks++; if (StallMem !== 1'b0 || RD_data !== 32'h55) begin failures++; $display("FAIL haz_done got=%0h/%h exp=0/00000055", StallMem, RD_data); end
    cyc();
`endif
    idleInputs();
    store(32'h400, 32'h0000_0077, 4'b0001);
    cyc();
    MemWriteM = 1'b0; MemReadM = 1'b1; ALUResultM = 32'h400;
    mid();
    checks++; if (StallMem !== 1'b1) begin failures++; $display("FAIL sb_haz_stall got=%0h exp=1", StallMem); end
    cyc();
    mem_ready = 1'b1;
    mid();
    checks++; if (StallMem !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL sb_haz_drain got=%0h/%0h exp=1/1", StallMem, mem_we); end
    cyc();
    mem_rdata = 32'h0000_0099;
    mid();
    checks++; if (mem_we !== 1'b0 || StallMem !== 1'b0 || RD_data !== 32'h99) begin failures++; $display("FAIL sb_haz_load got=%0h/%0h/%h exp=0/0/00000099", mem_we, StallMem, RD_data); end
    cyc();
    idleInputs();
    mid();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL haz_idle got=%0h exp=0", mem_req); end
    cyc();
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      store(32'h500 + 32'(4 * i), 32'hF0 + 32'(i), 4'b1111);
      cyc();
    end
    MemWriteM = 1'b0;
    mid();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin failures++; $display("FAIL rm_busy got=%0h/%h exp=1/00000500", mem_req, mem_addr); end
    #2 clr_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rm_drop got=%0h exp=0", mem_req); end
    @(posedge clk);
    #3 clr_n = 1'b1;
    cyc();
    mem_ready = 1'b1;
    mid();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rm_idle1 got=%0h exp=0", mem_req); end
    cyc();
    mid();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rm_idle2 got=%0h exp=0", mem_req); end
    cyc();
    store(32'h600, 32'h0000_00A5, 4'b1111);
    cyc();
    MemWriteM = 1'b0;
    mid();
    checks++; if (mem_addr !== 32'h600 || mem_wdata !== 32'hA5) begin failures++; $display("FAIL rm_fresh got=%h/%h exp=00000600/000000a5", mem_addr, mem_wdata); end
    cyc();
    mid();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rm_empty got=%0h exp=0", mem_req); end
    cyc();
    idleInputs();
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sub_word();
    test_full();
    test_load();
    test_hazard();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Data-memory interface stage sitting directly downstream of the pipeline datapath's MEM stage. It consumes the MEM-stage address, store data, byte enables and write strobe, posts stores into a DEPTH-entry FIFO and drains them to a single-port valid/ready memory bus. Loads take that bus through a small FSM, and the block returns lane-aligned load data to the datapath's load extender. It raises a stall to the hazard unit whenever the MEM stage cannot complete this cycle.

## Interface

- DEPTH, 4: store FIFO entries (power of two, ≥2)
- clk  in  1  clock, rising edge
- clr_n  in  1  reset; asynchronous, active-low
- MemWriteM  in  1  store in MEM stage
- MemReadM  in  1  load in MEM stage
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data, unaligned (value in low bits)
- byteEnable  in  4  lane mask from datapath
- StallMem  out  1  MEM stage cannot complete; hazard unit freezes F–M, bubbles W
- RD_data  out  32  word read for the load extender
- mem_req  out  1  bus request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_wdata  out  32  lane-aligned write data
- mem_be  out  4  write lane mask
- mem_ready  in  1  bus accepts/completes request this cycle
- mem_rdata  in  32  read data, valid when mem_ready and !mem_we

## Operation

- Store enqueue: MemWriteM & ~StallMem & ~MemReadM pushes {ALUResultM[31:2], WriteDataM << (8*ALUResultM[1:0]), byteEnable} at the tail.
- Store stall: FIFO full and MemWriteM raises StallMem, unless a dequeue happens the same cycle. Simultaneous enqueue and dequeue when full is allowed.
- MemWriteM & MemReadM together is illegal. The block treats it as a load.
- FSM states:
  - IDLE: mem_req = 0.
  - DRAIN: head entry on the bus with mem_we = 1.
  - LOAD: mem_addr = {ALUResultM[31:2], 2'b00}, mem_we = 0.
- IDLE transitions:
  - To LOAD if a load is pending and there is no hazard.
  - Else to DRAIN if the FIFO is non-empty.
  - Else stay in IDLE.
- DRAIN transitions:
  - Bus signals are held stable until mem_ready. Loads never preempt a presented drain.
  - On mem_ready the head dequeues. Next state is chosen by the IDLE priority, using the post-dequeue count.
- LOAD transitions:
  - On mem_ready, RD_data = mem_rdata and StallMem = 0 that cycle.
  - Next state is DRAIN if non-empty, else IDLE.
- Load hazard: the load word address equals the address of any valid FIFO entry. The load stalls (no LOAD issue) while drains continue, until no entry matches.
- StallMem = (pending load not yet completed) | (store blocked by full FIFO).
- RD_data = mem_rdata outside forwarding.

## Timing

- Reset (clr_n low, async): FIFO empty, pointers 0, state IDLE, mem_req 0. StallMem and RD_data then follow combinational inputs (0 when no load/store pending).
- Reset mid-transaction: the request is dropped at once and FIFO contents are discarded. The bus tolerates the abort.
- Store with FIFO not full: 0 stall cycles; the entry is visible the next cycle.
- Load (no hazard, FSM in IDLE, FIFO empty):
  - Cycle 0: StallMem = 1.
  - Cycle 1: mem_req = 1.
  - Completes in the first cycle mem_ready = 1, so minimum 1 stall cycle.
- Load arriving during DRAIN: waits for the drain's mem_ready, then takes LOAD at the next edge.
- Back-to-back drains: no idle cycle between entries.
- mem_ready → StallMem is a combinational path. The bus drives mem_ready from a register.
- Pointer wrap: modulo DEPTH. Full/empty are distinguished by an extra pointer bit.

## Configuration

- STORE_BUF_FWD_EN defined: on a load hazard, if the youngest matching entry has byte enable 4'b1111, RD_data = that entry's data in the same cycle. There is no stall and no bus access; this is allowed in any FSM state. Otherwise the load stalls as normal.
- Undefined: every hazard stalls until the matching entries drain. No forwarding logic is built.

## Test plan

- Reset, then sw 0xDEADBEEF to 0x100 with mem_ready tied 1:
  - 0 stall cycles.
  - Next cycle mem_req = 1, mem_we = 1, mem_addr = 0x100, mem_be = 1111.
  - The FIFO is empty after 1 cycle.
- sb 0xAB to 0x203 → mem_wdata = 0xAB000000, mem_be = 1000. sh 0x1234 to 0x202 → mem_wdata = 0x12340000, mem_be = 1100.
- Five stores with mem_ready = 0 (DEPTH = 4):
  - The fifth store sees StallMem = 1.
  - Raising mem_ready for one cycle dequeues the head and enqueues the fifth in the same cycle.
  - Count stays 4.
- Load from 0x300, FIFO empty, mem_ready asserted 3 cycles after mem_req:
  - StallMem is high for 4 cycles.
  - RD_data = mem_rdata exactly in the mem_ready cycle.
- sw 0x11223344 to 0x400, then lw 0x400 with mem_ready = 0:
  - FWD undefined: load stalls until the entry drains, then issues LOAD.
  - STORE_BUF_FWD_EN defined: RD_data = 0x11223344 with no stall.
  - An sb to 0x400 instead always stalls.
- Assert clr_n low during DRAIN with 3 entries queued → mem_req drops immediately. After release the FIFO is empty and the state is IDLE.
